// File: rtl/case_3_mul_share_ctrl.sv
// Purpose: shares one signed multiplier (low DOUT_W bits of a*b) among NUM_REQ requesters, round-robin.
// Latency: 1 cycle accept->rsp_valid; 2 cycles with CASE_3_MUL_SHARE_PIPE_EN defined (adds EXEC stage).
// Backpressure: one result slot; no grant while the held result is unretired (retire+grant same cycle ok).
module case_3_mul_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DIN0_W  = 6,
    parameter int DIN1_W  = 6,
    parameter int DOUT_W  = 6,
    parameter int CNT_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DIN0_W-1:0]   req_a,
    input  logic [NUM_REQ*DIN1_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DOUT_W-1:0]           rsp_data,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            op_count
);

    localparam int PW = DIN0_W + DIN1_W;

`ifdef CASE_3_MUL_SHARE_PIPE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1, ST_EXEC = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd1} state_t;
`endif

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win_idx;
    logic               win_found;
    int                 cand;
    logic               retire;
    logic               grant_ok;
    logic               grant;
    logic [DIN0_W-1:0]  a_sel;
    logic [DIN1_W-1:0]  b_sel;
    logic [DIN0_W-1:0]  mul_a;
    logic [DIN1_W-1:0]  mul_b;
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic [DOUT_W-1:0]  prod_lo;

`ifdef CASE_3_MUL_SHARE_PIPE_EN
    logic [DIN0_W-1:0]  exec_a;
    logic [DIN1_W-1:0]  exec_b;
    logic [ID_W-1:0]    exec_id;
`endif

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
    end

    // Grant qualification and the one-hot ready vector; nothing is granted during reset.
    always_comb begin
        retire    = (state == ST_HOLD) && rsp_ready[rsp_id];
        grant_ok  = (state == ST_IDLE) || retire;
        grant     = ap_rst_n && grant_ok && win_found;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant && (win_idx == ID_W'(i));
        end
    end

    // Operand select for the winner and the shared multiplier (full-width product, truncated).
    always_comb begin
        a_sel = req_a[win_idx*DIN0_W +: DIN0_W];
        b_sel = req_b[win_idx*DIN1_W +: DIN1_W];
`ifdef CASE_3_MUL_SHARE_PIPE_EN
        mul_a = exec_a;
        mul_b = exec_b;
`else
        mul_a = a_sel;
        mul_b = b_sel;
`endif
        a_ext   = PW'($signed(mul_a));
        b_ext   = PW'($signed(mul_b));
        prod_lo = DOUT_W'(a_ext * b_ext);
    end

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a retire with a simultaneous grant keeps the slot occupied.
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef CASE_3_MUL_SHARE_PIPE_EN
            ST_IDLE: if (grant) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_HOLD;
            ST_HOLD: if (retire) state_nxt = grant ? ST_EXEC : ST_IDLE;
`else
            ST_IDLE: if (grant) state_nxt = ST_HOLD;
            ST_HOLD: if (retire) state_nxt = grant ? ST_HOLD : ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration pointer and saturating accepted-operation counter.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ptr      <= '0;
            op_count <= '0;
        end else if (grant) begin
            ptr <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (op_count != {CNT_W{1'b1}}) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

`ifdef CASE_3_MUL_SHARE_PIPE_EN
    // Operand stage: capture the winner's operands and id at accept.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            exec_a  <= '0;
            exec_b  <= '0;
            exec_id <= '0;
        end else if (grant) begin
            exec_a  <= a_sel;
            exec_b  <= b_sel;
            exec_id <= win_idx;
        end
    end

    // Result slot: loaded from the multiplier as EXEC completes.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (state == ST_EXEC) begin
            rsp_data <= prod_lo;
            rsp_id   <= exec_id;
        end
    end
`else
    // Result slot: loaded directly at accept.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (grant) begin
            rsp_data <= prod_lo;
            rsp_id   <= win_idx;
        end
    end
`endif

    // Result valid only toward the owner of the held result.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state == ST_HOLD) && (rsp_id == ID_W'(i));
        end
        busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_case_3_mul_share_ctrl.sv
// Bench for case_3_mul_share_ctrl: directed vector table, hand-written corner sequences,
// then constrained-random traffic compared cycle by cycle against a transaction-level model.
module tb_case_3_mul_share_ctrl;

    localparam int N = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*6-1:0] req_a;
    logic [N*6-1:0] req_b;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready;
    logic [5:0]    rsp_data;
    logic [1:0]    rsp_id;
    logic          busy;
    logic [15:0]   op_count;

    case_3_mul_share_ctrl dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 ap_clk = ~ap_clk;

`ifdef CASE_3_MUL_SHARE_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    int nvec = 0;
    int nerr = 0;

    // Transaction-level model: a result slot, an optional in-flight op, pointer and count.
    bit         m_full, m_exec, m_granted;
    int         m_id, m_eid, m_ptr, m_cnt, m_win;
    logic [5:0] m_data, m_edata;

    typedef struct {
        int         id;
        int         a;
        int         b;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [5:0] mul6(input logic [5:0] a, input logic [5:0] b);
        int ia;
        int ib;
        int p;
        ia = $signed(a);
        ib = $signed(b);
        p  = ia * ib;
        return p[5:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_exec = 0; m_id = 0; m_eid = 0;
        m_ptr = 0; m_cnt = 0; m_data = '0; m_edata = '0;
    endtask

    // Called just after a falling edge with inputs already applied: compare, advance model, step one clock.
    task automatic cycle();
        bit         retire, can, found;
        logic [3:0] e_rdy;
        logic [3:0] e_vld;
        logic [5:0] d;
        retire = m_full && rsp_ready[m_id];
        can    = ap_rst_n && !m_exec && (!m_full || retire);
        found  = 0;
        m_win  = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && req_valid[j]) begin
                found = 1;
                m_win = j;
            end
        end
        m_granted = can && found;
        e_rdy = '0;
        if (m_granted) e_rdy[m_win] = 1'b1;
        e_vld = '0;
        if (m_full) e_vld[m_id] = 1'b1;
        #1;
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_vld));
        chk("busy",      32'(busy),      32'(m_full || m_exec));
        chk("op_count",  32'(op_count),  32'(m_cnt));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("rsp_data",  32'(rsp_data),  32'(m_data));
        if (!ap_rst_n) begin
            model_reset();
        end else begin
            if (retire) m_full = 0;
            if (m_exec) begin
                m_full = 1; m_id = m_eid; m_data = m_edata; m_exec = 0;
            end
            if (m_granted) begin
                d = mul6(req_a[m_win*6 +: 6], req_b[m_win*6 +: 6]);
                if (PIPE) begin
                    m_exec = 1; m_eid = m_win; m_edata = d;
                end else begin
                    m_full = 1; m_id = m_win; m_data = d;
                end
                m_ptr = (m_win + 1) % N;
                if (m_cnt != 32'hFFFF) m_cnt++;
            end
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic do_reset();
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        cycle();
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hold_r;
        logic [3:0] exp_rr;
        bit         got;

        tbl[0] = '{1,   3,   5, 6'd15};
        tbl[1] = '{0,   7,   5, 6'b100011};
        tbl[2] = '{2, -32, -32, 6'd0};
        tbl[3] = '{3,  -1,   1, 6'b111111};
        tbl[4] = '{3,  -2,   4, 6'b111000};
        tbl[5] = '{2,  31,  31, 6'd1};
        tbl[6] = '{0, -32,  31, 6'd32};

        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        model_reset();

        // Reset held for 3 cycles with every requester valid.
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_op_count",  32'(op_count),  32'd0);
            cycle();
        end
        ap_rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0001);
        cycle();

        // Vector table: single requester, result checked after the accept latency.
        do_reset();
        rsp_ready = 4'b1111;
        for (int t = 0; t < 7; t++) begin
            req_valid = '0;
            req_valid[tbl[t].id] = 1'b1;
            req_a[tbl[t].id*6 +: 6] = 6'(tbl[t].a);
            req_b[tbl[t].id*6 +: 6] = 6'(tbl[t].b);
            got = 0;
            for (int w = 0; w < 8 && !got; w++) begin
                cycle();
                got = m_granted;
            end
            if (!got) begin
                nvec++;
                nerr++;
                $display("FAIL grant_timeout: vector %0d never accepted", t);
            end
            req_valid = '0;
            if (PIPE) cycle();
            #1;
            chk("tbl_rsp_valid", 32'(rsp_valid), 32'(1 << tbl[t].id));
            chk("tbl_rsp_data",  32'(rsp_data),  32'(tbl[t].exp));
            chk("tbl_rsp_id",    32'(rsp_id),    32'(tbl[t].id));
            chk("tbl_op_count",  32'(op_count),  32'(t + 1));
            cycle();
        end

        // All requesters valid continuously: strict rotation.
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (PIPE) exp_rr = (k % 2 == 0) ? 4'(1 << ((k / 2) % 4)) : 4'b0000;
            else      exp_rr = 4'(1 << (k % 4));
            #1;
            chk("rr_order", 32'(req_ready), 32'(exp_rr));
            cycle();
        end

        // Owner 2 stalls its result; requester 0 waits; a non-owner ready is ignored.
        do_reset();
        req_valid = 4'b0100;
        req_a[2*6 +: 6] = 6'd13;
        req_b[2*6 +: 6] = 6'd11;
        rsp_ready = 4'b0000;
        cycle();
        req_valid = 4'b0001;
        req_a[0 +: 6] = 6'd2;
        req_b[0 +: 6] = 6'd3;
        if (PIPE) cycle();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rsp_id",    32'(rsp_id),    32'd2);
            chk("stall_rsp_data",  32'(rsp_data),  32'(6'd15));
            cycle();
        end
        rsp_ready = 4'b0001;
        #1;
        chk("nonowner_ready", 32'(req_ready), 32'd0);
        cycle();
        rsp_ready = 4'b0100;
        #1;
        chk("retire_grant", 32'(req_ready), 32'b0001);
        cycle();
        req_valid = '0;
        rsp_ready = 4'b1111;
        repeat (3) cycle();

        // Reset right after accept: the result must never surface.
        do_reset();
        req_valid = 4'b1000;
        req_a[3*6 +: 6] = 6'(-2);
        req_b[3*6 +: 6] = 6'd4;
        rsp_ready = 4'b1111;
        cycle();
        req_valid = '0;
        ap_rst_n  = 1'b0;
        cycle();
        ap_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
            cycle();
        end

        // Random traffic under the hold-operands-while-waiting rule.
        hold_r = '0;
        for (int c = 0; c < 3000; c++) begin
            ap_rst_n  = ($urandom_range(0, 199) != 0);
            rsp_ready = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!hold_r[i]) begin
                    req_valid[i]   = ($urandom_range(0, 9) < 6);
                    req_a[i*6 +: 6] = 6'($urandom);
                    req_b[i*6 +: 6] = 6'($urandom);
                end
            end
            cycle();
            for (int i = 0; i < N; i++) begin
                hold_r[i] = req_valid[i] && !(m_granted && m_win == i);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/case_3_mul_share_ctrl.md
Name: case_3_mul_share_ctrl

Overview:
- Shares one signed multiplier among NUM_REQ requesters.
- The multiplier is the 6s x 6s -> 6 type: full signed product, truncated to the low DOUT_W bits.
- Round-robin arbitration, valid/ready handshake on both sides, one registered result slot tagged with its owner.
- Sits between HLS-generated dataflow processes that would otherwise each instantiate a private multiplier.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN0_W, 6, signed width of operand a.
- DIN1_W, 6, signed width of operand b.
- DOUT_W, 6, result width; low DOUT_W bits of the signed product.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*DIN0_W  packed operand a; requester i at bits [i*DIN0_W +: DIN0_W].
- req_b  in  NUM_REQ*DIN1_W  packed operand b, same packing.
- rsp_valid  out  NUM_REQ  result valid, asserted only for the owner of the held result.
- rsp_ready  in  NUM_REQ  per-requester result accept.
- rsp_data  out  DOUT_W  held result, shared by all requesters.
- rsp_id  out  clog2(NUM_REQ)  owner index of the held result.
- busy  out  1  result slot occupied or operation in flight.
- op_count  out  CNT_W  number of accepted operations; saturates at all-ones.

Behaviour:
- Reset (ap_rst_n=0 at an edge):
  - State goes to IDLE.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, op_count=0.
  - Round-robin pointer set to 0.
  - req_ready is 0 while ap_rst_n=0.
  - Reset mid-operation discards the held or in-flight result; no rsp_valid follows.
- States:
  - IDLE: slot empty.
  - HOLD: result held.
- Grant:
  - A grant is possible when the state is IDLE, or when the state is HOLD and rsp_ready[rsp_id]=1 in the same cycle (back-to-back, throughput 1 op/cycle).
  - When a grant is possible, the winner is the first i with req_valid[i]=1, searching from the pointer upward with wrap.
  - req_ready[winner]=1 combinationally in that cycle; all other req_ready bits are 0.
- Handshake completes at the edge where req_valid[i]=1 and req_ready[i]=1. At that edge:
  - rsp_data <= low DOUT_W bits of signed(a_i) * signed(b_i).
  - rsp_id <= i.
  - State goes to HOLD.
  - Pointer <= (i+1) mod NUM_REQ.
  - op_count increments unless it is already saturated.
- Latency: 1 cycle from accept to rsp_valid.
- HOLD:
  - rsp_valid[rsp_id]=1; other rsp_valid bits are 0.
  - rsp_data and rsp_id stay stable until retire.
  - Retire occurs on rsp_ready[rsp_id]=1. With no new grant the state goes to IDLE; with a new grant it stays in HOLD holding the new result.
  - rsp_ready bits of non-owners are ignored.
- busy = (state != IDLE).
- Pointer is unchanged when nothing is granted. No requester waits more than NUM_REQ-1 grants.
- Requesters must hold a and b stable while req_valid=1 and req_ready=0. The block never drops a valid request.
- Arithmetic: the product is formed at DIN0_W+DIN1_W bits and then truncated; there is no saturation.

Optional Feature:
- Macro: CASE_3_MUL_SHARE_PIPE_EN.
- Defined:
  - Adds an operand/product register stage and a third state EXEC, giving the flow IDLE -> EXEC -> HOLD.
  - Accept-to-rsp_valid latency is 2 cycles.
  - A grant is possible only in IDLE, or in HOLD on retire with no op in EXEC; at most one operation is in flight.
  - busy=1 in EXEC.
  - Reset clears the EXEC stage.
- Undefined: single-stage behaviour as described above; the EXEC state does not exist.

Test Plan:
- Reset with req_valid=4'b1111 and ap_rst_n=0 for 3 cycles -> req_ready=0, rsp_valid=0, op_count=0 throughout; the first grant after release goes to requester 0.
- Requester 1 only, a=3, b=5, rsp_ready held at 1 -> accept at cycle t; at t+1 rsp_valid=4'b0010, rsp_data=6'd15, rsp_id=1; op_count=1.
- Truncation checks:
  - a=7, b=5 -> rsp_data=6'b100011 (-29).
  - a=-32, b=-32 -> rsp_data=0.
  - a=-1, b=1 -> rsp_data=6'b111111.
- All four requesters valid continuously, rsp_ready=all ones -> grant order 0,1,2,3,0,...; one accept per cycle; op_count advances by 1 each cycle.
- Owner 2 holding a result with rsp_ready[2]=0 for 5 cycles while requester 0 is valid -> req_ready=0, and rsp_data and rsp_id stay stable. Raising rsp_ready[0] alone has no effect. When rsp_ready[2] rises, requester 0 is granted in that same cycle.
- With CASE_3_MUL_SHARE_PIPE_EN defined: requester 3, a=-2, b=4 -> rsp_valid[3] rises 2 cycles after accept with rsp_data=6'b111000 (-8). Asserting reset while in EXEC produces no rsp_valid.
